display_scroll_controller: RTL
==============================

# display_scroll_controller

Sequencer and arbiter for the character load port of the multiplexed LED display. It holds a 16-entry message buffer and periodically rewrites all four display character positions from a scrolling window into that buffer. It also arbitrates the load port between this scroll engine and a manual single-character writer driven from the input switches. It sits between the top-level pin decode and the display character multiplexer, and drives that block's data, position and load inputs.

## Interface
Parameters:
- SCROLL_TICKS, default 24'd10_000_000: clock cycles per scroll step; legal range is 8 or more.

Ports (one clock; reset is synchronous and active-high):
- clk  in  1  system clock; all state updates on the rising edge
- reset  in  1  synchronous, active-high reset
- wr_en  in  1  write one message buffer entry this cycle
- wr_addr  in  4  buffer entry index
- wr_data  in  4  character code to store
- msg_len  in  4  index of the last valid entry; message length is msg_len+1
- scroll_en  in  1  enables the scroll timer
- man_req  in  1  manual load request
- man_data  in  4  manual character code
- man_pos  in  2  manual target position
- man_ack  out  1  one-cycle grant and completion pulse for a manual load
- disp_data  out  4  character code to the display
- disp_pos  out  2  target character position
- disp_load  out  1  one-cycle load strobe
- busy  out  1  high while the state is REFRESH or MANUAL
- frame_done  out  1  one-cycle pulse on the last load of a refresh

## Operation
- Buffer: 16×4 flops.
  - Written when wr_en is high, in any state.
  - A write becomes visible to reads on the next cycle, so a same-cycle read returns the old value.
- Scroll timer:
  - While scroll_en is high, tick_cnt counts 0..SCROLL_TICKS-1 and then wraps to 0.
  - When tick_cnt equals SCROLL_TICKS-1, the pending flag is set.
  - While scroll_en is low, tick_cnt is held at 0 and pending is cleared. A refresh already in progress still completes.
  - A tick that arrives while pending is already set is dropped; ticks are not counted.
- FSM states: IDLE, REFRESH, MANUAL.
  - IDLE → MANUAL if man_req is high. Manual requests have priority over a pending refresh.
  - Otherwise IDLE → REFRESH if pending is set; pending is cleared on entry.
  - REFRESH issues four loads on consecutive cycles, for positions 0, 1, 2, 3, then returns to IDLE.
    - The data for position p is buf[(head+p) mod (msg_len+1)], using true modulo. For example, msg_len=0 gives all four positions buf[0].
    - A refresh is never preempted. A man_req that arrives during REFRESH waits in IDLE arbitration.
  - MANUAL issues one load with the values of man_data and man_pos sampled in IDLE, pulses man_ack, then returns to IDLE.
- Head pointer:
  - Updated when a refresh ends: head ← 0 if head ≥ msg_len, else head+1.
  - If msg_len is lowered so that head > msg_len, head is treated as 0 for index computation, and the next advance produces 0.
- Outputs are registered.
  - disp_data and disp_pos hold their last driven value when disp_load is low.

## Timing
- Reset, synchronous: applies to every register.
  - Outputs after reset: disp_data=0, disp_pos=0, disp_load=0, man_ack=0, busy=0, frame_done=0.
  - Internal state after reset: head=0, tick_cnt=0, pending=0, all buffer entries 0, state IDLE.
  - Reset during REFRESH or MANUAL aborts the operation immediately, and no further loads are issued.
- Refresh latency: tick_cnt=SCROLL_TICKS-1 in cycle N
  - N+1: pending set.
  - N+2..N+5: disp_load high, with disp_pos 0, 1, 2, 3.
  - N+5: frame_done high.
  - N+6: head advanced.
  - busy is high N+2..N+5.
- Manual handshake:
  - man_req is sampled high in IDLE in cycle M.
  - In M+1: disp_load=1, man_ack=1, busy=1.
  - The requester must drop man_req in the ack cycle.
  - The earliest next grant is M+3, because IDLE resamples in M+2.
- Simultaneous man_req and pending in IDLE: the manual load goes first, and the refresh starts on the cycle after the state returns to IDLE.
- Throughput: at most one disp_load per cycle. There is never more than one strobe per position per refresh.

## Test plan
- Reset then idle:
  - Stimulus: hold reset 2 cycles with scroll_en=0.
  - Required: every output stays 0; no disp_load for 100 cycles.
- Basic scroll:
  - Stimulus: SCROLL_TICKS=8; buf = 1, 2, 3, 4, 5 with msg_len=4; scroll_en=1.
  - First frame: loads 1, 2, 3, 4 on positions 0..3.
  - Following frames: 2, 3, 4, 5, then 3, 4, 5, 1, and so on.
  - Frames are spaced exactly 8 cycles apart, with frame_done on each 4th load.
- Wrap with short message:
  - Stimulus: msg_len=1 with buf[0]=7, buf[1]=9.
  - Required frames: 7, 9, 7, 9, then 9, 7, 9, 7, then 7, 9, 7, 9.
- Manual priority:
  - Stimulus: man_req=1 with man_data=0xA and man_pos=2, asserted in the same cycle pending becomes visible.
  - Required: a single load of A at position 2 with man_ack, followed one IDLE cycle later by the 4-load refresh.
  - man_req raised mid-refresh is granted only after the fourth load.
- Reset mid-refresh:
  - Stimulus: assert reset on the 2nd load cycle.
  - Required: no further disp_load; head=0; the next frame starts from buf[0].
- Write hazard and msg_len shrink:
  - Write buf[1]=F in the cycle position 0 reads buf[1] (head=1). Required: the old value is loaded, and the next frame shows F.
  - Drop msg_len from 7 to 2 while head=5. Required: the next frame uses head 0.

Source files
------------

// File: rtl/display_scroll_controller.sv
// display_scroll_controller: scroll engine and manual-write arbiter
// driving the character load port of the LED display multiplexer.
module display_scroll_controller #(
    parameter logic [23:0] SCROLL_TICKS = 24'd10_000_000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       wr_en,
    input  logic [3:0] wr_addr,
    input  logic [3:0] wr_data,
    input  logic [3:0] msg_len,
    input  logic       scroll_en,
    input  logic       man_req,
    input  logic [3:0] man_data,
    input  logic [1:0] man_pos,
    output logic       man_ack,
    output logic [3:0] disp_data,
    output logic [1:0] disp_pos,
    output logic       disp_load,
    output logic       busy,
    output logic       frame_done
);
    typedef enum logic [1:0] {
        S_IDLE,
        S_REFRESH,
        S_MANUAL
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [3:0]  r_buf [16];
    logic [23:0] r_tick_cnt;
    logic        r_pending;
    logic [3:0]  r_head;
    logic [1:0]  r_cnt;
    logic [3:0]  r_disp_data;
    logic [1:0]  r_disp_pos;
    logic        r_disp_load;
    logic        r_man_ack;
    logic        r_busy;
    logic        r_frame_done;

    logic        w_tick_last;
    logic [3:0]  w_head_eff;
    logic [1:0]  w_p;
    logic [4:0]  w_sum;
    logic [4:0]  w_len;
    logic [3:0]  w_rd_idx;
    logic        w_load_nxt;
    logic        w_ack_nxt;
    logic        w_done_nxt;
    logic [3:0]  w_data_nxt;
    logic [1:0]  w_pos_nxt;
    logic [1:0]  w_cnt_nxt;
    logic        w_take_pend;
    logic        w_head_adv;

    assign w_tick_last = (r_tick_cnt == SCROLL_TICKS - 24'd1);

    // A head left beyond a shortened message restarts from entry 0
    assign w_head_eff = (r_head > msg_len) ? 4'd0 : r_head;
    assign w_p        = (r_state == S_REFRESH) ? r_cnt + 2'd1 : 2'd0;
    assign w_sum      = {1'b0, w_head_eff} + {3'b000, w_p};
    assign w_len      = {1'b0, msg_len} + 5'd1;
    assign w_rd_idx   = 4'(w_sum % w_len);

    always_comb begin
        w_state_nxt = r_state;
        w_load_nxt  = 1'b0;
        w_ack_nxt   = 1'b0;
        w_done_nxt  = 1'b0;
        w_data_nxt  = r_disp_data;
        w_pos_nxt   = r_disp_pos;
        w_cnt_nxt   = r_cnt;
        w_take_pend = 1'b0;
        w_head_adv  = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (man_req) begin
                    w_state_nxt = S_MANUAL;
                    w_load_nxt  = 1'b1;
                    w_ack_nxt   = 1'b1;
                    w_data_nxt  = man_data;
                    w_pos_nxt   = man_pos;
                end else if (r_pending) begin
                    w_state_nxt = S_REFRESH;
                    w_take_pend = 1'b1;
                    w_load_nxt  = 1'b1;
                    w_data_nxt  = r_buf[w_rd_idx];
                    w_pos_nxt   = 2'd0;
                    w_cnt_nxt   = 2'd0;
                end
            end
            S_REFRESH: begin
                if (r_cnt == 2'd3) begin
                    w_state_nxt = S_IDLE;
                    w_head_adv  = 1'b1;
                end else begin
                    w_load_nxt = 1'b1;
                    w_data_nxt = r_buf[w_rd_idx];
                    w_pos_nxt  = w_p;
                    w_cnt_nxt  = w_p;
                    w_done_nxt = (w_p == 2'd3);
                end
            end
            S_MANUAL: w_state_nxt = S_IDLE;
            default:  w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 16; i++) r_buf[i] <= 4'd0;
            r_tick_cnt   <= 24'd0;
            r_pending    <= 1'b0;
            r_head       <= 4'd0;
            r_cnt        <= 2'd0;
            r_disp_data  <= 4'd0;
            r_disp_pos   <= 2'd0;
            r_disp_load  <= 1'b0;
            r_man_ack    <= 1'b0;
            r_busy       <= 1'b0;
            r_frame_done <= 1'b0;
        end else begin
            if (wr_en) r_buf[wr_addr] <= wr_data;
            if (!scroll_en) begin
                r_tick_cnt <= 24'd0;
                r_pending  <= 1'b0;
            end else begin
                r_tick_cnt <= w_tick_last ? 24'd0 : r_tick_cnt + 24'd1;
                if (w_take_pend) r_pending <= 1'b0;
                else if (w_tick_last) r_pending <= 1'b1;
            end
            if (w_head_adv) begin
                r_head <= (r_head >= msg_len) ? 4'd0 : r_head + 4'd1;
            end
            r_cnt        <= w_cnt_nxt;
            r_disp_data  <= w_data_nxt;
            r_disp_pos   <= w_pos_nxt;
            r_disp_load  <= w_load_nxt;
            r_man_ack    <= w_ack_nxt;
            r_busy       <= (w_state_nxt != S_IDLE);
            r_frame_done <= w_done_nxt;
        end
    end

    assign disp_data  = r_disp_data;
    assign disp_pos   = r_disp_pos;
    assign disp_load  = r_disp_load;
    assign man_ack    = r_man_ack;
    assign busy       = r_busy;
    assign frame_done = r_frame_done;
endmodule
